lfsr_checker: RTL and testbench

Receive-side companion to the team's 16-bit pseudo-random bit generator. It consumes the serial bit stream produced by the generator, self-synchronizes to it without knowing the seed, then predicts every subsequent bit and flags mismatches. It sits at the sink of a link or datapath under test and reports lock status and error counts for bit-error-rate measurement.

---
 rtl/lfsr_checker.sv | 183 ++++++++++++++++++
 tb/tb_lfsr_checker.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_checker.sv
// lfsr_checker
// Receive-side checker for the 16-bit pseudo-random bit stream
// b[n] = b[n-16] ^ b[n-14] ^ b[n-13] ^ b[n-11].
// The checker fills a 16-bit history window from the received bits until it
// holds a usable (non-zero) seed. From then on it predicts each bit from the
// window, flags mismatches, and keeps a saturating error count. Too many errors
// inside one evaluation window drop lock and restart the fill.

module lfsr_checker #(
   parameter int ERR_WINDOW = 64,   // valid bits per loss-of-lock window (>= 2)
   parameter int ERR_THRESH = 4     // errors per window that drop lock (1..ERR_WINDOW)
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rx_valid,
   input  logic        rx_bit,
   input  logic        clr_cnt,
   output logic        locked,
   output logic        err,
   output logic        lost,
   output logic [15:0] err_count
);

   // ------------------------------------------------------------------
   // Local constants
   // ------------------------------------------------------------------
   localparam int WB_W = (ERR_WINDOW > 1) ? $clog2(ERR_WINDOW) : 1;
   localparam int WE_W = $clog2(ERR_THRESH + 1);

   localparam logic [WB_W-1:0] WIN_LAST   = WB_W'(ERR_WINDOW - 1);
   localparam logic [WE_W-1:0] THRESH     = WE_W'(ERR_THRESH);
   localparam logic [4:0]      FILL_LAST  = 5'd15;
   localparam logic [15:0]     CNT_MAX    = 16'hFFFF;

   localparam logic [0:0] ST_SYNC   = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   // ------------------------------------------------------------------
   // State registers and their next-state values
   // ------------------------------------------------------------------
   logic [0:0]      state_q,     state_d;
   logic [15:0]     w_q,         w_d;          // w[0] oldest, w[15] newest
   logic [4:0]      fill_q,      fill_d;
   logic [WB_W-1:0] win_bits_q,  win_bits_d;
   logic [WE_W-1:0] win_errs_q,  win_errs_d;
   logic            err_q,       err_d;
   logic            lost_q,      lost_d;
   logic [15:0]     err_count_q, err_count_d;

   // ------------------------------------------------------------------
   // Datapath helpers
   // ------------------------------------------------------------------
   logic            is_locked;
   logic            exp_bit;
   logic            shift_in;
   logic [15:0]     w_shift;
   logic            mismatch;
   logic [WE_W-1:0] win_errs_inc;
   logic            thresh_hit;
   logic            fill_done;
   logic            window_zero;
   logic            window_end;

   // Prediction, mismatch detection and the candidate shifted window
   always_comb begin
      is_locked = (state_q == ST_LOCKED);
      exp_bit   = w_q[0] ^ w_q[2] ^ w_q[3] ^ w_q[5];

      // Once locked, the window is advanced with the prediction so that a
      // corrupted received bit never pollutes later predictions.
      shift_in  = is_locked ? exp_bit : rx_bit;
      w_shift   = {shift_in, w_q[15:1]};

      mismatch  = rx_valid && is_locked && (rx_bit != exp_bit);

      // Window error count including the current bit; never exceeds THRESH
      // because lock is dropped as soon as THRESH is reached.
      win_errs_inc = win_errs_q + WE_W'(mismatch);
      thresh_hit   = mismatch && (win_errs_inc >= THRESH);
      window_end   = (win_bits_q == WIN_LAST);

      fill_done    = rx_valid && !is_locked && (fill_q == FILL_LAST);
      window_zero  = (w_shift == 16'h0000);
   end

   // Lock state machine, history window, fill and loss-of-lock window counters
   always_comb begin
      state_d    = state_q;
      w_d        = w_q;
      fill_d     = fill_q;
      win_bits_d = win_bits_q;
      win_errs_d = win_errs_q;
      err_d      = 1'b0;
      lost_d     = 1'b0;

      if (rx_valid) begin
         w_d = w_shift;

         case (state_q)
            ST_SYNC: begin
               if (fill_done) begin
                  // Sixteen bits collected: an all-zero window cannot seed
                  // the generator, so keep filling; otherwise start checking.
                  fill_d = 5'd0;
                  if (!window_zero) begin
                     state_d    = ST_LOCKED;
                     win_bits_d = '0;
                     win_errs_d = '0;
                  end
               end else begin
                  fill_d = fill_q + 5'd1;
               end
            end

            ST_LOCKED: begin
               err_d = mismatch;
               if (thresh_hit) begin
                  // Too many errors in this window: give up and resync.
                  state_d    = ST_SYNC;
                  fill_d     = 5'd0;
                  win_bits_d = '0;
                  win_errs_d = '0;
                  lost_d     = 1'b1;
               end else if (window_end) begin
                  win_bits_d = '0;
                  win_errs_d = '0;
               end else begin
                  win_bits_d = win_bits_q + WB_W'(1);
                  win_errs_d = win_errs_inc;
               end
            end

            default: begin
               state_d = ST_SYNC;
               fill_d  = 5'd0;
            end
         endcase
      end
   end

   // Saturating error counter with synchronous clear; a clear that coincides
   // with a counted error leaves that error in the count.
   always_comb begin
      err_count_d = err_count_q;
      if (clr_cnt) begin
         err_count_d = {15'd0, mismatch};
      end else if (mismatch && (err_count_q != CNT_MAX)) begin
         err_count_d = err_count_q + 16'd1;
      end
   end

   // Register bank; reset discards all synchronization progress
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_SYNC;
         w_q         <= 16'h0000;
         fill_q      <= 5'd0;
         win_bits_q  <= '0;
         win_errs_q  <= '0;
         err_q       <= 1'b0;
         lost_q      <= 1'b0;
         err_count_q <= 16'h0000;
      end else begin
         state_q     <= state_d;
         w_q         <= w_d;
         fill_q      <= fill_d;
         win_bits_q  <= win_bits_d;
         win_errs_q  <= win_errs_d;
         err_q       <= err_d;
         lost_q      <= lost_d;
         err_count_q <= err_count_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs, all straight from registers
   // ------------------------------------------------------------------
   assign locked    = (state_q == ST_LOCKED);
   assign err       = err_q;
   assign lost      = lost_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker
// Table-driven bench: each record holds the inputs for one clock and the
// outputs required just after that clock edge. A reference generator supplies
// the stream bits; expected outputs are written from the known positions of
// lock, injected errors and clears. Reset cases are hand-written sequences.

module tb_lfsr_checker;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rx_valid;
   logic        rx_bit;
   logic        clr_cnt;
   logic        locked;
   logic        err;
   logic        lost;
   logic [15:0] err_count;

   always #5 clk = ~clk;

   lfsr_checker #(
      .ERR_WINDOW (64),
      .ERR_THRESH (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx_valid  (rx_valid),
      .rx_bit    (rx_bit),
      .clr_cnt   (clr_cnt),
      .locked    (locked),
      .err       (err),
      .lost      (lost),
      .err_count (err_count)
   );

   typedef struct {
      logic        valid;
      logic        rxb;
      logic        clr;
      logic        e_locked;
      logic        e_err;
      logic        e_lost;
      logic [15:0] e_cnt;
   } vec_t;

   vec_t tbl[$];
   int   n_vec  = 0;
   int   n_miss = 0;

   localparam logic [15:0] SEED = 16'hECEB;
   logic [15:0] gen_hist;
   int          gen_idx;

   // Reference generator: seed bits first (LSB first), then the recurrence
   task automatic gen_bit(output logic b);
      if (gen_idx < 16) b = SEED[gen_idx];
      else              b = gen_hist[0] ^ gen_hist[2] ^ gen_hist[3] ^ gen_hist[5];
      gen_hist = {b, gen_hist[15:1]};
      gen_idx++;
   endtask

   task automatic add_raw(input logic v, input logic b, input logic c,
                          input logic el, input logic ee, input logic elost,
                          input logic [15:0] ecnt);
      vec_t r;
      r.valid = v; r.rxb = b; r.clr = c;
      r.e_locked = el; r.e_err = ee; r.e_lost = elost; r.e_cnt = ecnt;
      tbl.push_back(r);
   endtask

   // Valid rows take the next generator bit (optionally inverted); idle rows
   // carry a random bit that must be ignored.
   task automatic add(input logic v, input logic flip, input logic c,
                      input logic el, input logic ee, input logic elost,
                      input logic [15:0] ecnt);
      logic g;
      if (v) begin
         gen_bit(g);
         add_raw(1'b1, g ^ flip, c, el, ee, elost, ecnt);
      end else begin
         add_raw(1'b0, 1'($urandom_range(0, 1)), c, el, ee, elost, ecnt);
      end
   endtask

   task automatic run_table(input string tag);
      foreach (tbl[i]) begin
         rx_valid = tbl[i].valid;
         rx_bit   = tbl[i].rxb;
         clr_cnt  = tbl[i].clr;
         @(posedge clk);
         #1;
         n_vec++;
         if (locked !== tbl[i].e_locked || err !== tbl[i].e_err ||
             lost !== tbl[i].e_lost || err_count !== tbl[i].e_cnt) begin
            n_miss++;
            $display("FAIL %s row %0d: got locked=%b err=%b lost=%b cnt=%0d, need locked=%b err=%b lost=%b cnt=%0d",
                     tag, i, locked, err, lost, err_count,
                     tbl[i].e_locked, tbl[i].e_err, tbl[i].e_lost, tbl[i].e_cnt);
         end else begin
            $display("%s row %0d v=%b b=%b clr=%b -> locked=%b err=%b lost=%b cnt=%0d ok",
                     tag, i, tbl[i].valid, tbl[i].rxb, tbl[i].clr,
                     locked, err, lost, err_count);
         end
      end
      rx_valid = 1'b0;
      clr_cnt  = 1'b0;
      tbl.delete();
   endtask

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] need);
      n_vec++;
      if (got !== need) begin
         n_miss++;
         $display("FAIL %s: got %0d, need %0d", name, got, need);
      end else begin
         $display("%s = %0d ok", name, got);
      end
   endtask

   initial begin
      int vcnt;
      int ecnt;
      logic v;
      logic f;

      rst_n    = 1'b0;
      rx_valid = 1'b0;
      rx_bit   = 1'b0;
      clr_cnt  = 1'b0;
      gen_hist = 16'h0000;
      gen_idx  = 0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset locked", 16'(locked), 16'd0);
      check("reset err", 16'(err), 16'd0);
      check("reset lost", 16'(lost), 16'd0);
      check("reset err_count", err_count, 16'd0);
      #2 rst_n = 1'b1;

      // Clean lock, single error at bit 200, clear, loss, relock, gaps
      for (int n = 0; n < 1000; n++)
         add(1'b1, n == 200, 1'b0, n >= 15, n == 200, 1'b0, 16'((n >= 200) ? 1 : 0));
      for (int n = 1000; n < 1020; n++)
         add(1'b1, 1'b0, n == 1005, 1'b1, 1'b0, 1'b0, 16'((n >= 1005) ? 0 : 1));
      for (int n = 1020; n <= 1026; n++)
         add(1'b1, (n % 2) == 0, 1'b0, n != 1026, (n % 2) == 0, n == 1026,
             16'((n - 1020) / 2 + 1));
      for (int n = 1027; n <= 1042; n++)
         add(1'b1, 1'b0, 1'b0, n == 1042, 1'b0, 1'b0, 16'd4);
      for (int n = 1043; n < 1300; n++)
         add(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd4);
      for (int k = 0; k < 60; k++)
         add(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd4);
      add(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'd1);   // clear together with an error
      add(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1);
      add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);   // clear on an idle cycle
      add(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
      run_table("stream");

      // Degenerate all-zero stream never locks
      rst_n = 1'b0;
      @(posedge clk);
      #3 rst_n = 1'b1;
      for (int k = 0; k < 100; k++)
         add_raw(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
      run_table("zeros");

      // Lock with random gaps, then three errors in one window
      rst_n = 1'b0;
      gen_idx  = 0;
      gen_hist = 16'h0000;
      @(posedge clk);
      #3 rst_n = 1'b1;
      vcnt = 0;
      ecnt = 0;
      while (vcnt < 200) begin
         v = 1'($urandom_range(0, 1));
         if (v) vcnt++;
         f = v && (vcnt == 50 || vcnt == 52 || vcnt == 54);
         if (f) ecnt++;
         add(v, f, 1'b0, vcnt >= 16, f, 1'b0, 16'(ecnt));
      end
      run_table("gaps");

      // Asynchronous reset between clock edges
      check("pre-reset locked", 16'(locked), 16'd1);
      check("pre-reset err_count", err_count, 16'd3);
      #3 rst_n = 1'b0;
      #1;
      check("async reset locked", 16'(locked), 16'd0);
      check("async reset err_count", err_count, 16'd0);
      check("async reset err", 16'(err), 16'd0);
      #2 rst_n = 1'b1;

      // Relock on the continuing stream after reset
      for (int k = 0; k < 16; k++)
         add(1'b1, 1'b0, 1'b0, k == 15, 1'b0, 1'b0, 16'd0);
      for (int k = 0; k < 40; k++)
         add(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
      run_table("relock");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
